line_prefetch_reader: RTL
=========================

Name: line_prefetch_reader

Overview:
- Parametrised successor to the single-word frame reader.
- Prefetches the next display line from SDRAM into one half of a ping-pong line buffer while the other half drives the VGA colour outputs.
- Sits between the vga_controller (DrawX/DrawY) and the sdram_master read handshake.
- Supports 1 or 2 pixels per 32-bit word, two selectable frame bases, and underrun detection.

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, visible lines per frame.
- V_TOTAL, 525, total lines per frame including blanking (y_pos wraps at V_TOTAL-1).
- PIX_PER_WORD, 2, pixels per 32-bit SDRAM word. Legal values: 1 (RGB888 in bits 23:0) or 2 (two RGB565 pixels).
- FRAME_BASE0, 26'h0000000, word address of frame 0.
- FRAME_BASE1, 26'h0040000, word address of frame 1.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high
- x_pos  in  10  DrawX from vga_controller
- y_pos  in  10  DrawY from vga_controller
- frame_sel  in  1  frame to display; sampled at line-0 fetch start
- data_in  in  32  read data from sdram_master
- ready  in  1  one-cycle pulse; data_in valid this cycle
- read_req  out  1  read request, level
- address  out  26  word address of the request
- red, green, blue  out  8 each  colour outputs
- underrun  out  1  sticky error flag
- busy  out  1  fetch in progress

Behaviour:
- Reset values: read_req=0, address=0, RGB=0, underrun=0, busy=0, both buffer-valid flags=0, FSM=IDLE.
- WPL = H_RES/PIX_PER_WORD words per line (320 at defaults). Buffer b (0/1) holds WPL words, a 10-bit line tag and a valid bit.
- Trigger: y_pos differs from its value on the previous Clk. The target line is T = (y_pos==V_TOTAL-1) ? 0 : y_pos+1. If T >= V_RES, no fetch. Otherwise a fetch of T into buffer T[0] starts.
- Fetch start:
  - Clears valid[T[0]] and sets tag[T[0]]=T.
  - When T==0, latches base = frame_sel ? FRAME_BASE1 : FRAME_BASE0.
- FSM:
  - IDLE -> REQ on trigger.
  - REQ: read_req=1; address = base + T*WPL + idx, held stable, modulo 2^26. Stays in REQ until ready.
  - On ready: store data_in at idx. If idx==WPL-1, set valid and go to IDLE. Otherwise idx+1 and go to GAP.
  - GAP: one cycle with read_req=0, then back to REQ.
  - busy=1 in REQ and GAP.
- Trigger while busy:
  - Sets underrun and records a pending restart.
  - If in GAP, the restart is immediate.
  - If in REQ, the outstanding read is never withdrawn. The word arriving with ready is discarded, then the FSM restarts for the new T with idx=0.
- Display:
  - RGB is registered, 1 Clk latency from x_pos/y_pos.
  - RGB=0 if x_pos>=H_RES, y_pos>=V_RES, valid[y_pos[0]]==0, or tag!=y_pos.
  - Word index = x_pos/PIX_PER_WORD.
  - PIX_PER_WORD=1: R=w[23:16], G=w[15:8], B=w[7:0].
  - PIX_PER_WORD=2: pixel = x_pos[0] ? w[31:16] : w[15:0]. Expand RGB565 as R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
- Underrun is also set when x_pos==0 and y_pos<V_RES while the line is not valid. It clears only on Reset.
- Reset mid-fetch: returns to IDLE next cycle with read_req=0 and all valid flags cleared. The sdram_master shares this reset, so no stale ready is expected.
- Buffer write and display read may occur in the same cycle on different halves; no conflict.
- The buffer is inferred as dual-port RAM; the read port is synchronous.

Test Plan:
- Reset held 3 cycles during REQ -> read_req=0, RGB=0, underrun=0; with y_pos held, no fetch restarts.
- y_pos 0->1, PIX_PER_WORD=2, frame_sel=0, memory model returns word=addr after 5 cycles:
  - 320 requests at addresses 2*320+0 .. 2*320+319 (640..959), each separated by a GAP cycle.
  - busy falls after the last ready; valid[0] set.
- Line 2 fetched with word 0 = 32'hFFFF_F800, then y_pos=2 and x_pos=0,1 -> RGB (FF,00,00) then (FF,FF,FF), 1 Clk after each x_pos.
- y_pos 524->0 with frame_sel=1:
  - Fetch of line 1 addresses from 26'h0040000+320.
  - Toggling frame_sel mid-frame does not change base until the next line-0 fetch.
- Memory latency 10 cycles:
  - y_pos advances before the fetch completes -> underrun=1.
  - The in-flight word is discarded; the new fetch restarts at idx 0.
  - The stale line outputs RGB=0.
- PIX_PER_WORD=1 build, word 32'h0012_3456 at x_pos=5 of a valid line -> RGB (12,34,56); x_pos=640 -> RGB 0.

Source files
------------

// File: rtl/line_prefetch_reader.sv
// Ping-pong line prefetcher: fills one buffer half from SDRAM while the
// other half drives the VGA colour outputs, with underrun detection.
module line_prefetch_reader #(
    parameter int          H_RES        = 640,
    parameter int          V_RES        = 480,
    parameter int          V_TOTAL      = 525,
    parameter int          PIX_PER_WORD = 2,
    parameter logic [25:0] FRAME_BASE0  = 26'h0000000,
    parameter logic [25:0] FRAME_BASE1  = 26'h0040000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        frame_sel,
    input  logic [31:0] data_in,
    input  logic        ready,
    output logic        read_req,
    output logic [25:0] address,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        underrun,
    output logic        busy
);
    localparam int WPL   = H_RES / PIX_PER_WORD;
    localparam int DEPTH = 2 * WPL;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(WPL);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [9:0]      line_q, line_d;
    logic [9:0]      pend_line_q, pend_line_d;
    logic            pend_q, pend_d;
    logic [25:0]     base_q;
    logic [9:0]      y_prev_q;
    logic [1:0]      valid_q;
    logic [1:0][9:0] tag_q;
    logic            underrun_q;
    logic [31:0]     mem [DEPTH];
    logic [31:0]     rd_word_q;
    logic            show_q;
    logic            hi_q;

    logic [9:0]    tgt;
    logic [9:0]    start_line;
    logic [9:0]    widx;
    logic          fetch_trig;
    logic          start;
    logic          wr_en;
    logic          done;
    logic          overrun;
    logic          in_area;
    logic          line_ok;
    logic          line_miss;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [15:0]   pix;

    // Line after the current one, wrapping at the end of the frame.
    assign tgt = (y_pos == 10'(V_TOTAL - 1)) ? 10'd0 : y_pos + 10'd1;
    assign fetch_trig = (y_pos != y_prev_q) && (tgt < 10'(V_RES));

    assign read_req = (state_q == REQ);
    assign busy     = (state_q != IDLE);
    assign underrun = underrun_q;
    assign address  = base_q + 26'(line_q) * 26'(WPL) + 26'(idx_q);

    assign wr_addr = line_q[0] ? AW'(WPL) + AW'(idx_q) : AW'(idx_q);

    assign in_area = (x_pos < 10'(H_RES)) && (y_pos < 10'(V_RES));
    assign line_ok = valid_q[y_pos[0]] && (tag_q[y_pos[0]] == y_pos);
    assign line_miss = (x_pos == 10'd0) && (y_pos < 10'(V_RES)) && !line_ok;
    assign widx = !in_area ? 10'd0 :
                  (PIX_PER_WORD == 2) ? {1'b0, x_pos[9:1]} : x_pos;
    assign rd_addr = y_pos[0] ? AW'(WPL) + AW'(widx) : AW'(widx);

    // Fetch FSM: next state, word index and restart bookkeeping.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        line_d      = line_q;
        pend_d      = pend_q;
        pend_line_d = pend_line_q;
        start       = 1'b0;
        start_line  = tgt;
        wr_en       = 1'b0;
        done        = 1'b0;
        overrun     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_trig) begin
                    start   = 1'b1;
                    state_d = REQ;
                end
            end
            GAP: begin
                state_d = REQ;
                if (fetch_trig) begin
                    start   = 1'b1;
                    overrun = 1'b1;
                end
            end
            REQ: begin
                if (fetch_trig) begin
                    overrun     = 1'b1;
                    pend_d      = 1'b1;
                    pend_line_d = tgt;
                end
                if (ready) begin
                    if (fetch_trig || pend_q) begin
                        // read cannot be withdrawn: drop its word, restart
                        start      = 1'b1;
                        start_line = fetch_trig ? tgt : pend_line_q;
                        pend_d     = 1'b0;
                    end else begin
                        wr_en = 1'b1;
                        if (idx_q == IW'(WPL - 1)) begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = GAP;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            idx_d  = '0;
            line_d = start_line;
        end
    end

    // Control registers, buffer flags, sticky underrun and display qualifiers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            line_q      <= '0;
            pend_q      <= 1'b0;
            pend_line_q <= '0;
            base_q      <= FRAME_BASE0;
            y_prev_q    <= y_pos;
            valid_q     <= '0;
            tag_q       <= '0;
            underrun_q  <= 1'b0;
            show_q      <= 1'b0;
            hi_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            pend_q      <= pend_d;
            pend_line_q <= pend_line_d;
            y_prev_q    <= y_pos;
            if (start && (start_line == 10'd0))
                base_q <= frame_sel ? FRAME_BASE1 : FRAME_BASE0;
            if (done)
                valid_q[line_q[0]] <= 1'b1;
            if (fetch_trig) begin
                valid_q[tgt[0]] <= 1'b0;
                tag_q[tgt[0]]   <= tgt;
            end
            if (overrun || line_miss)
                underrun_q <= 1'b1;
            show_q <= in_area && line_ok;
            hi_q   <= x_pos[0];
        end
    end

    // Dual-port line buffer with a synchronous read port.
    always_ff @(posedge Clk) begin
        if (wr_en && !Reset)
            mem[wr_addr] <= data_in;
        rd_word_q <= mem[rd_addr];
    end

    // Colour decode of the registered buffer word.
    always_comb begin
        pix   = hi_q ? rd_word_q[31:16] : rd_word_q[15:0];
        red   = 8'd0;
        green = 8'd0;
        blue  = 8'd0;
        if (show_q) begin
            if (PIX_PER_WORD == 1) begin
                red   = rd_word_q[23:16];
                green = rd_word_q[15:8];
                blue  = rd_word_q[7:0];
            end else begin
                red   = {pix[15:11], pix[15:13]};
                green = {pix[10:5], pix[10:9]};
                blue  = {pix[4:0], pix[4:2]};
            end
        end
    end
endmodule
